// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet transmit path: FSM states, frame
// geometry, the default bit period and the packet checksum helper.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CK,
    SEND_ADDR,
    SEND_CNT,
    SEND_DATA,
    WAIT_LAST
  } tx_state_t;

  // start bit + 8 data bits + stop bit
  localparam int UART_BITS_PER_FRAME = 10;

  // Same bit period the receiving demux uses.
  localparam int DEFAULT_CLKS_PER_BIT = 23;

  // Checksum byte that makes the 8-bit sum of the whole packet equal zero.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] data_sum,
                                              input logic [7:0] addr,
                                              input logic [7:0] cnt);
    logic [7:0] total;
    total = data_sum + addr + cnt;
    return 8'(~total + 8'd1);
  endfunction

endpackage

// File: rtl/uart_packet_tx_byte.sv
// uart_byte_tx: 8N1 serialiser. Accepts one byte on valid&&ready while idle
// and shifts it out LSB first; ready is high only while no frame is in flight.
module uart_byte_tx
  import uart_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [CW-1:0] clk_cnt;

  assign ready = ~active;

  // Frame sequencer: load on handshake, hold each bit CLKS_PER_BIT clocks,
  // return to idle at the end of the stop bit. The line is driven from a flop.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      active  <= 1'b0;
      frame   <= '1;
      bit_idx <= '0;
      clk_cnt <= '0;
      tx      <= 1'b1;
    end else if (!active) begin
      if (valid) begin
        active  <= 1'b1;
        frame   <= {1'b1, data, 1'b0};
        bit_idx <= '0;
        clk_cnt <= '0;
        tx      <= 1'b0;
      end
    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      if (bit_idx == 4'(UART_BITS_PER_FRAME - 1)) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= frame[bit_idx + 4'd1];
      end
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: buffers payload bytes, then sends
//   checksum | address | count | data...
// on UART_TX so that the 8-bit sum of the packet is zero.
// Optional build macro UART_PKT_TX_AUTOSTART_EN: a write that fills the FIFO
// while idle launches a packet with the current pkt_addr.
module uart_packet_tx
  import uart_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  input  logic [7:0] pkt_addr,
  input  logic       pkt_start,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       UART_TX
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] level;
  logic [7:0]    sum;
  logic [7:0]    addr_q;
  logic [7:0]    cnt_q;
  logic [7:0]    hdr_byte;
  tx_state_t     state;

  logic          ser_valid;
  logic          ser_ready;
  logic [7:0]    ser_data;

  logic          wr_ok;
  logic          start_req;
  logic          start_ok;
  logic          handshake;
  logic [AW-1:0] level_wr;
  logic [7:0]    sum_wr;
  logic [7:0]    cnt_start;
  logic [7:0]    ck_start;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Write acceptance, start qualification and header values for this cycle.
  // A write accepted in the same cycle as a start is part of that packet.
  always_comb begin
    wr_ok     = wr_en && (state == IDLE) && (level != AW'(DEPTH));
    level_wr  = wr_ok ? level + AW'(1) : level;
    sum_wr    = wr_ok ? sum + wr_data : sum;
`ifdef UART_PKT_TX_AUTOSTART_EN
    start_req = pkt_start || (wr_ok && (level_wr == AW'(DEPTH)));
`else
    start_req = pkt_start;
`endif
    start_ok  = start_req && (state == IDLE) && (level_wr != '0);
    cnt_start = 8'(level_wr);
    ck_start  = pkt_checksum(sum_wr, pkt_addr, cnt_start);
    handshake = ser_valid && ser_ready;
    ser_data  = (state == SEND_DATA) ? mem[rd_ptr] : hdr_byte;
  end

  // Payload storage; only pointers and level need resetting.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Packet FSM: loads the FIFO while idle, then walks the header bytes and
  // drains the payload through the serialiser, one byte per handshake.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      sum       <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      hdr_byte  <= '0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      full      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && !wr_ok) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
            level  <= level_wr;
            sum    <= sum_wr;
            full   <= (level_wr == AW'(DEPTH));
          end
          if (start_ok) begin
            addr_q    <= pkt_addr;
            cnt_q     <= cnt_start;
            hdr_byte  <= ck_start;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND_CK;
          end
        end
        SEND_CK: begin
          if (handshake) begin
            hdr_byte <= addr_q;
            state    <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (handshake) begin
            hdr_byte <= cnt_q;
            state    <= SEND_CNT;
          end
        end
        SEND_CNT: begin
          if (handshake) state <= SEND_DATA;
        end
        SEND_DATA: begin
          if (handshake) begin
            rd_ptr <= ptr_inc(rd_ptr);
            level  <= level - AW'(1);
            full   <= 1'b0;
            if (level == AW'(1)) begin
              ser_valid <= 1'b0;
              state     <= WAIT_LAST;
            end
          end
        end
        WAIT_LAST: begin
          if (ser_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            sum   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .RESET(RESET),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (UART_TX)
  );

endmodule

// File: tb/tb_uart_packet_tx.sv
// Testbench for uart_packet_tx. A packet-level model turns buffered writes
// into the expected byte stream; a line decoder recovers bytes from UART_TX
// and a per-cycle process checks busy/done/overflow and the idle line.
// Honours UART_PKT_TX_AUTOSTART_EN when the design is built with it.
module tb_uart_packet_tx;

  localparam int CPB   = 23;
  localparam int DEPTH = 16;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] wr_data   = 8'h00;
  logic       wr_en     = 1'b0;
  logic [7:0] pkt_addr  = 8'h00;
  logic       pkt_start = 1'b0;
  logic       full;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       uart_tx;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_fifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         rx_idx     = 0;
  int         starts     = 0;
  int         done_count = 0;
  int         rst_count  = 0;
  bit         model_ovf  = 1'b0;
  bit         checking   = 1'b0;

  uart_packet_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .RESET    (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .pkt_addr (pkt_addr),
    .pkt_start(pkt_start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .UART_TX  (uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge rst) rst_count++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Model: a packet is checksum, address, count, payload; all bytes sum to 0.
  task automatic queue_packet(input logic [7:0] addr);
    int total;
    logic [7:0] cnt;
    cnt   = 8'(model_fifo.size());
    total = int'(addr) + int'(cnt);
    foreach (model_fifo[i]) total += int'(model_fifo[i]);
    exp_q.push_back(8'((256 - (total % 256)) % 256));
    exp_q.push_back(addr);
    exp_q.push_back(cnt);
    foreach (model_fifo[i]) exp_q.push_back(model_fifo[i]);
    model_fifo.delete();
    starts++;
  endtask

  // One input cycle; the model is updated just after the sampling edge.
  task automatic applyStimulus(input bit do_wr, input logic [7:0] data,
                               input bit do_start, input logic [7:0] addr);
    bit pend;
    @(posedge clk); #1;
    wr_en     = do_wr;
    wr_data   = data;
    pkt_start = do_start;
    pkt_addr  = addr;
    @(posedge clk); #1;
    pend = (starts != done_count);
    if (do_wr) begin
      if (pend || model_fifo.size() == DEPTH) begin
        model_ovf = 1'b1;
      end else begin
        model_fifo.push_back(data);
`ifdef UART_PKT_TX_AUTOSTART_EN
        if (model_fifo.size() == DEPTH) begin
          queue_packet(addr);
          pend = 1'b1;
        end
`endif
      end
    end
    if (do_start && !pend && model_fifo.size() > 0) queue_packet(addr);
    wr_en     = 1'b0;
    pkt_start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst       = 1'b1;
    model_ovf = 1'b0;
    model_fifo.delete();
    while (exp_q.size() > rx_idx) void'(exp_q.pop_back());
    starts = done_count;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) checkOutput("done_seen", done, 1);
  endtask

  task automatic pin_bytes(input string name, input int base, input int n, input logic [63:0] lit);
    logic [63:0] v;
    v = lit;
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_%0d", name, i), exp_q[base + i], v[8*(n-1-i) +: 8]);
  endtask

  // Line decoder: samples each bit mid-period and checks against the model.
  task automatic receive_frame();
    int snap;
    logic [9:0] bits;
    snap = rst_count;
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
      if (rst || rst_count != snap) return;
      bits[b] = uart_tx;
    end
    checkOutput("frame_start_bit", bits[0], 0);
    checkOutput("frame_stop_bit", bits[9], 1);
    checkOutput("frame_expected", rx_idx < exp_q.size(), 1);
    if (rx_idx < exp_q.size())
      checkOutput($sformatf("byte%0d", rx_idx), bits[8:1], exp_q[rx_idx]);
    rx_log.push_back(bits[8:1]);
    rx_idx++;
  endtask

  always begin
    @(negedge uart_tx);
    if (!rst && checking) receive_frame();
  end

  // Per-cycle checks of the control outputs against the model.
  always @(negedge clk) begin
    if (checking && !rst) begin
      if (done === 1'b1) begin
        checkOutput("done_when_all_sent", (starts != done_count) && (rx_idx == exp_q.size()), 1);
        if (starts != done_count) done_count++;
      end
      checkOutput("overflow", overflow, model_ovf);
      checkOutput("busy", busy, starts != done_count);
      if (starts == done_count) checkOutput("tx_idle", uart_tx, 1);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, lat, cyc, bsum, n;

    // reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_uart_tx", uart_tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_full", full, 0);
    checking = 1'b1;

    // basic 3-byte packet
    base = rx_idx;
    applyStimulus(1, 8'h01, 0, 8'h00);
    applyStimulus(1, 8'h02, 0, 8'h00);
    applyStimulus(1, 8'h03, 0, 8'h00);
    applyStimulus(0, 8'h00, 1, 8'h12);
    pin_bytes("pktA_model", base, 6, 64'h0000_E512_0301_0203);
    lat = 0;
    do begin @(negedge clk); lat++; end while (uart_tx !== 1'b0 && lat < 6);
    checkRange("start_latency", lat, 1, 3);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 2000);
    checkRange("fall_to_done_clocks", cyc, 1380, 1386);
    checkOutput("pktA_frames", rx_idx - base, 6);
    bsum = 0;
    for (int i = base; i < rx_idx; i++) bsum += int'(rx_log[i]);
    checkOutput("pktA_byte_sum", bsum % 256, 0);

    // start with an empty FIFO is ignored
    applyStimulus(0, 8'h00, 1, 8'h33);
    repeat (60) @(negedge clk);
    checkOutput("empty_start_busy", busy, 0);
    checkOutput("empty_start_no_frame", rx_idx - base, 6);

    // 17 writes into a 16-deep FIFO
    base = rx_idx;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 8'(8'h30 + i), 0, 8'h21);
      if (i == 15) checkOutput("full_after_16", full, 1);
    end
    checkOutput("overflow_after_17", overflow, 1);
    applyStimulus(0, 8'h00, 1, 8'h21);
    checkOutput("pkt16_count_pin", exp_q[base + 2], 8'h10);
    repeat (30) @(posedge clk);
    applyStimulus(0, 8'h00, 1, 8'h77);
    applyStimulus(1, 8'hEE, 0, 8'h00);
    wait_done(5000);
    @(negedge clk);
    checkOutput("pkt16_frames", rx_idx - base, 19);
    checkOutput("pkt16_full_after", full, 0);

    // reset in the middle of the first data byte
    base = rx_idx;
    applyStimulus(1, 8'h77, 0, 8'h00);
    applyStimulus(0, 8'h00, 1, 8'h05);
    n = 0;
    while (rx_idx - base < 3 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("hdr_bytes_before_reset", rx_idx - base, 3);
    repeat (20) @(negedge clk);
    checkOutput("tx_low_before_reset", uart_tx, 0);
    do_reset();
    #1;
    checkOutput("tx_high_on_reset", uart_tx, 1);
    checkOutput("busy_low_on_reset", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("overflow_after_reset", overflow, 0);
    checkOutput("full_after_reset", full, 0);

    // 1-byte packet after the abort, with a write dropped while busy
    base = rx_idx;
    applyStimulus(1, 8'hAA, 0, 8'h00);
    applyStimulus(0, 8'h00, 1, 8'h00);
    pin_bytes("pktE_model", base, 4, 64'h0000_0000_5500_01AA);
    repeat (5) @(posedge clk);
    applyStimulus(1, 8'h99, 0, 8'h00);
    wait_done(2000);
    @(negedge clk);
    checkOutput("pktE_frames", rx_idx - base, 4);
    applyStimulus(0, 8'h00, 1, 8'h10);
    repeat (60) @(negedge clk);
    checkOutput("dropped_byte_absent", rx_idx - base, 4);

`ifdef UART_PKT_TX_AUTOSTART_EN
    // filling the FIFO launches a packet without pkt_start
    base = rx_idx;
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i * 3), 0, 8'h40);
    checkOutput("auto_started", starts - done_count, 1);
    checkOutput("auto_count_pin", exp_q[base + 2], 8'h10);
    wait_done(5000);
    @(negedge clk);
    checkOutput("auto_frames", rx_idx - base, 19);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
